// File: rtl/dsi_link_scheduler_if.sv
// Bundle between the DSI link scheduler, its two word-stream sources, and the lanes controller.
// Ports: s0_* and s1_* carry source word streams, iface_* is the lanes-controller write port,
// lines_/clock_ carry the lane power handshake, and busy/grant_src/err_* report status.
// The master modport is the scheduler's view. The slave modport is the environment's view.
`timescale 1ns/1ps
interface dsi_link_scheduler_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    logic              s0_valid;
    logic              s0_last;
    logic [DATA_W-1:0] s0_data;
    logic [STRB_W-1:0] s0_strb;
    logic              s0_ready;

    logic              s1_valid;
    logic              s1_last;
    logic [DATA_W-1:0] s1_data;
    logic [STRB_W-1:0] s1_strb;
    logic              s1_ready;

    logic [DATA_W-1:0] iface_write_data;
    logic [STRB_W-1:0] iface_write_strb;
    logic              iface_write_rqst;
    logic              iface_last_word;
    logic              iface_data_rqst;

    logic              lines_enable;
    logic              clock_enable;
    logic              lines_ready;
    logic              clock_ready;

    logic              busy;
    logic              grant_src;
    logic              err_timeout;
    logic              err_underrun;

    modport master (
        input  s0_valid, s0_last, s0_data, s0_strb,
        output s0_ready,
        input  s1_valid, s1_last, s1_data, s1_strb,
        output s1_ready,
        output iface_write_data, iface_write_strb, iface_write_rqst, iface_last_word,
        input  iface_data_rqst,
        output lines_enable, clock_enable,
        input  lines_ready, clock_ready,
        output busy, grant_src, err_timeout, err_underrun
    );

    modport slave (
        output s0_valid, s0_last, s0_data, s0_strb,
        input  s0_ready,
        output s1_valid, s1_last, s1_data, s1_strb,
        input  s1_ready,
        input  iface_write_data, iface_write_strb, iface_write_rqst, iface_last_word,
        output iface_data_rqst,
        input  lines_enable, clock_enable,
        output lines_ready, clock_ready,
        input  busy, grant_src, err_timeout, err_underrun
    );
endinterface

// File: rtl/dsi_link_scheduler.sv
// DSI link scheduler. It powers the lanes up on demand and arbitrates two word sources round-robin.
// It streams one packet at a time to the lanes controller, then powers the lanes down after an idle period.
// Ports: clk_sys and rst (synchronous, active-high); bus carries everything else through the master modport.
`timescale 1ns/1ps
module dsi_link_scheduler #(
    parameter int unsigned IDLE_TIMEOUT = 64,
    parameter int unsigned PWR_GAP      = 10,
    parameter int unsigned RDY_TIMEOUT  = 1023
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    dsi_link_scheduler_if.master bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned MAX_AB  = (IDLE_TIMEOUT > PWR_GAP) ? IDLE_TIMEOUT : PWR_GAP;
    localparam int unsigned CNT_MAX = (MAX_AB > RDY_TIMEOUT) ? MAX_AB : RDY_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        OFF, LINES_UP, GAP, CLK_UP, IDLE, SEND_FIRST, SEND, CLK_DOWN, LINES_DOWN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              wrqst_q, wrqst_d;
    logic              wlast_q, wlast_d;
    logic              rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic              len_q, len_d, cen_q, cen_d, busy_q, busy_d;
    logic              err_to_q, err_to_d, err_ur_q, err_ur_d;

    logic              sel_valid, sel_last, sel_rdy, any_valid, pick, tmo;
    logic [DATA_W-1:0] sel_data;
    logic [STRB_W-1:0] sel_strb;

    // Granted-source view and arbitration decision.
    always_comb begin
        sel_valid = grant_q ? bus.s1_valid : bus.s0_valid;
        sel_last  = grant_q ? bus.s1_last  : bus.s0_last;
        sel_data  = grant_q ? bus.s1_data  : bus.s0_data;
        sel_strb  = grant_q ? bus.s1_strb  : bus.s0_strb;
        sel_rdy   = grant_q ? rdy1_q       : rdy0_q;
        any_valid = bus.s0_valid | bus.s1_valid;
        // When only one source requests, it wins. On a tie, the source not granted last time wins.
        pick      = (bus.s0_valid & bus.s1_valid) ? ~last_grant_q : bus.s1_valid;
        tmo       = (cnt_q == CNT_W'(RDY_TIMEOUT));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wlast_d      = wlast_q;
        wrqst_d      = 1'b0;
        rdy0_d       = 1'b0;
        rdy1_d       = 1'b0;
        err_to_d     = err_to_q;
        err_ur_d     = err_ur_q;

        case (state_q)
            OFF: begin
                cnt_d = '0;
                if (any_valid) state_d = LINES_UP;
            end
            LINES_UP: begin
                if (bus.lines_ready) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d  = OFF;
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(PWR_GAP - 1)) begin
                    state_d = CLK_UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLK_UP: begin
                if (bus.clock_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d  = OFF;
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (any_valid) begin
                    state_d      = SEND_FIRST;
                    cnt_d        = '0;
                    grant_d      = pick;
                    last_grant_d = pick;
                end else if (cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                    state_d = CLK_DOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEND_FIRST: begin
                wdata_d = sel_data;
                wstrb_d = sel_strb;
                wlast_d = sel_last;
                wrqst_d = 1'b1;
                rdy0_d  = ~grant_q;
                rdy1_d  = grant_q;
                state_d = SEND;
            end
            SEND: begin
                // Ready is registered, so the source advances one cycle after a capture.
                // A request in that cycle would capture a stale word, so it is ignored.
                if (bus.iface_data_rqst && !sel_rdy) begin
                    if (wlast_q) begin
                        wdata_d = '0;
                        wstrb_d = '0;
                        wlast_d = 1'b0;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (sel_valid) begin
                        wdata_d = sel_data;
                        wstrb_d = sel_strb;
                        wlast_d = sel_last;
                        rdy0_d  = ~grant_q;
                        rdy1_d  = grant_q;
                    end else begin
                        // Underrun: close the packet with an empty final word.
                        err_ur_d = 1'b1;
                        wdata_d  = '0;
                        wstrb_d  = '0;
                        wlast_d  = 1'b1;
                    end
                end
            end
            CLK_DOWN: begin
                if (!bus.clock_ready) begin
                    state_d = LINES_DOWN;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d  = OFF;
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LINES_DOWN: begin
                if (!bus.lines_ready) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d  = OFF;
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase

        // Enables and busy follow the upcoming state, so the registered outputs line up with state_q.
        len_d  = (state_d != OFF) && (state_d != LINES_DOWN);
        cen_d  = (state_d == CLK_UP) || (state_d == IDLE) ||
                 (state_d == SEND_FIRST) || (state_d == SEND);
        busy_d = (state_d != OFF);
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q      <= OFF;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wrqst_q      <= 1'b0;
            wlast_q      <= 1'b0;
            rdy0_q       <= 1'b0;
            rdy1_q       <= 1'b0;
            len_q        <= 1'b0;
            cen_q        <= 1'b0;
            busy_q       <= 1'b0;
            err_to_q     <= 1'b0;
            err_ur_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wrqst_q      <= wrqst_d;
            wlast_q      <= wlast_d;
            rdy0_q       <= rdy0_d;
            rdy1_q       <= rdy1_d;
            len_q        <= len_d;
            cen_q        <= cen_d;
            busy_q       <= busy_d;
            err_to_q     <= err_to_d;
            err_ur_q     <= err_ur_d;
        end
    end

    assign bus.s0_ready         = rdy0_q;
    assign bus.s1_ready         = rdy1_q;
    assign bus.iface_write_data = wdata_q;
    assign bus.iface_write_strb = wstrb_q;
    assign bus.iface_write_rqst = wrqst_q;
    assign bus.iface_last_word  = wlast_q;
    assign bus.lines_enable     = len_q;
    assign bus.clock_enable     = cen_q;
    assign bus.busy             = busy_q;
    assign bus.grant_src        = grant_q;
    assign bus.err_timeout      = err_to_q;
    assign bus.err_underrun     = err_ur_q;
endmodule

// File: doc/dsi_link_scheduler.md
DSI_LINK_SCHEDULER -- requirements
Module: dsi_link_scheduler

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 64: clk_sys cycles with no pending request in IDLE before link power-down.
REQ-002 Parameter PWR_GAP, default 10: clk_sys cycles between lines_ready rising and clock_enable assertion.
REQ-003 Parameter RDY_TIMEOUT, default 1023: maximum clk_sys cycles spent waiting for any ready edge.
REQ-004 The block SHALL have one clock and synchronous active-high reset: clk_sys, rst.
REQ-005 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 s0_valid, s0_last  in  1 each; s0_data  in  32; s0_strb  in  4; s0_ready  out  1: source 0 (video) word stream.
REQ-008 s1_valid, s1_last  in  1 each; s1_data  in  32; s1_strb  in  4; s1_ready  out  1: source 1 (command) word stream.
REQ-009 iface_write_data  out  32; iface_write_strb  out  4; iface_write_rqst  out  1; iface_last_word  out  1; iface_data_rqst  in  1: lanes-controller write port.
REQ-010 lines_enable, clock_enable  out  1 each; lines_ready, clock_ready  in  1 each: lane power handshake.
REQ-011 busy  out  1 (state not OFF); grant_src  out  1 (source of current/last packet); err_timeout, err_underrun  out  1 each, sticky.

Function
REQ-012 FSM states: OFF, LINES_UP, GAP, CLK_UP, IDLE, SEND_FIRST, SEND, CLK_DOWN, LINES_DOWN.
REQ-013 OFF -> LINES_UP when s0_valid or s1_valid; lines_enable asserted from LINES_UP through LINES_DOWN exclusive.
REQ-014 LINES_UP -> GAP on lines_ready=1; GAP counts PWR_GAP cycles -> CLK_UP; clock_enable asserted from CLK_UP through CLK_DOWN exclusive.
REQ-015 CLK_UP -> IDLE on clock_ready=1.
REQ-016 In IDLE, arbitration SHALL be round-robin: single valid source wins; both valid -> source not granted last; after reset last-grant=1, so s0 wins first tie.
REQ-017 Grant latches grant_src and moves to SEND_FIRST next cycle; packet is never interrupted by the other source.
REQ-018 SEND_FIRST (one cycle): register granted source data/strb/last onto iface_write_*, pulse iface_write_rqst=1 for exactly one cycle, pulse sX_ready=1 same cycle; -> SEND.
REQ-019 SEND, presented word not last, iface_data_rqst=1 and source valid: pulse sX_ready one cycle, register next word/strb/last on next edge.
REQ-020 SEND, presented word not last, iface_data_rqst=1 and source not valid: set err_underrun, present strb=0, last=1; packet terminates as REQ-021.
REQ-021 SEND, presented word has last=1, iface_data_rqst=1: clear iface_write_data/strb/last to 0 next edge, -> IDLE; single-word packets follow this directly after SEND_FIRST.
REQ-022 sX_ready SHALL never assert for the non-granted source or outside SEND_FIRST/SEND.
REQ-023 IDLE idle counter: increments each cycle with no valid source, clears on any valid; reaching IDLE_TIMEOUT -> CLK_DOWN.
REQ-024 CLK_DOWN: clock_enable=0, -> LINES_DOWN on clock_ready=0; LINES_DOWN: lines_enable=0, -> OFF on lines_ready=0.
REQ-025 Request arriving during CLK_DOWN/LINES_DOWN SHALL wait; power-down completes to OFF, then REQ-013 restarts power-up.
REQ-026 Any wait state (LINES_UP, CLK_UP, CLK_DOWN, LINES_DOWN) exceeding RDY_TIMEOUT cycles: set err_timeout, deassert both enables, -> OFF.
REQ-027 Sticky errors clear only on rst.

Reset
REQ-028 rst=1 at any edge, including mid-packet: state OFF; all outputs 0; counters 0; last-grant=1; grant_src=0; in-flight packet discarded without sX_ready.
REQ-029 Outputs SHALL remain 0 in the first cycle after rst deasserts.

Verification
REQ-030 Power-up: s0_valid=1 from OFF, lines_ready 5 cycles later, clock_ready 3 cycles after clock_enable -> clock_enable rises exactly PWR_GAP=10 cycles after lines_ready; SEND_FIRST follows clock_ready by 2 cycles.
REQ-031 10-word s0 packet (strb f...f, last strb 3), data_rqst pulses every 4 cycles -> 1 write_rqst pulse, 10 s0_ready pulses, words in order, last_word with strb 4'h3, then IDLE.
REQ-032 Tie: s0,s1 both valid in IDLE twice -> s0 packet, then s1 packet, grant_src 0 then 1.
REQ-033 Underrun: s1 drops valid after word 2 of 4 -> err_underrun=1, third presented word strb 0, last 1, return to IDLE.
REQ-034 Idle power-down: no requests 64 cycles -> clock_enable 0, then lines_enable 0 after clock_ready falls; lines_ready held 1 for 1024 cycles -> err_timeout=1, state OFF.
REQ-035 rst mid-SEND -> all outputs 0 next cycle, busy=0, no further sX_ready.
